ntt_cmd_sched: RTL and testbench

- Command queue and issue sequencer in front of the NTT engine, which accepts one command at a time.
- Buffers tagged commands from the host/decoder in a FIFO and issues them one at a time on the engine's cmd_valid/ready handshake.
- Tracks completion by watching engine ready and reports a per-command done/tag.
- Drops illegal opcodes with an error completion so the engine never sees them.

---
 rtl/ntt_cmd_sched_if.sv | 43 ++++
 rtl/ntt_cmd_sched.sv | 150 +++++++++++++++
 tb/tb_ntt_cmd_sched.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/ntt_cmd_sched_if.sv
// ntt_cmd_sched_if: host command, engine issue and completion signals of ntt_cmd_sched.
// wdog_trip exists only when NTT_SCHED_WDOG_EN is defined.
interface ntt_cmd_sched_if #(
   parameter int TAG_W   = 8,
   parameter int FIFO_AW = 3
);
   logic               in_valid;
   logic               in_ready;
   logic [7:0]         in_opcode;
   logic [3:0]         in_slot;
   logic [47:0]        in_dma_addr;
   logic [TAG_W-1:0]   in_tag;
   logic               flush;
   logic               eng_cmd_valid;
   logic [7:0]         eng_cmd_opcode;
   logic [3:0]         eng_cmd_slot;
   logic [47:0]        eng_cmd_dma_addr;
   logic               eng_ready;
   logic               done_valid;
   logic [TAG_W-1:0]   done_tag;
   logic               done_err;
   logic               busy;
   logic [FIFO_AW:0]   fifo_count;
`ifdef NTT_SCHED_WDOG_EN
   logic               wdog_trip;
`endif
   modport master (
      output in_valid, in_opcode, in_slot, in_dma_addr, in_tag, flush, eng_ready,
      input  in_ready, eng_cmd_valid, eng_cmd_opcode, eng_cmd_slot, eng_cmd_dma_addr,
             done_valid, done_tag, done_err, busy, fifo_count
`ifdef NTT_SCHED_WDOG_EN
             , wdog_trip
`endif
   );
   modport slave (
      input  in_valid, in_opcode, in_slot, in_dma_addr, in_tag, flush, eng_ready,
      output in_ready, eng_cmd_valid, eng_cmd_opcode, eng_cmd_slot, eng_cmd_dma_addr,
             done_valid, done_tag, done_err, busy, fifo_count
`ifdef NTT_SCHED_WDOG_EN
             , wdog_trip
`endif
   );
endinterface

// File: rtl/ntt_cmd_sched.sv
// ntt_cmd_sched: command FIFO and one-at-a-time issue sequencer for the NTT engine.
// Optional completion watchdog enabled by defining NTT_SCHED_WDOG_EN.
module ntt_cmd_sched #(
   parameter int FIFO_DEPTH  = 8,
   parameter int FIFO_AW     = 3,
   parameter int TAG_W       = 8
`ifdef NTT_SCHED_WDOG_EN
   , parameter int WDOG_CYCLES = 65536
`endif
) (
   input logic            clk,
   input logic            rst,
   ntt_cmd_sched_if.slave io
);
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE} state_t;
   localparam int EW = 60 + TAG_W;
   logic [EW-1:0]      mem_q [FIFO_DEPTH];
   logic [EW-1:0]      head;
   logic [FIFO_AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [FIFO_AW:0]   cnt_q, cnt_d;
   state_t             st_q, st_d;
   logic               vld_q, vld_d, dv_q, dv_d, derr_q, derr_d;
   logic [7:0]         op_q, op_d;
   logic [3:0]         slot_q, slot_d;
   logic [47:0]        addr_q, addr_d;
   logic [TAG_W-1:0]   tag_q, tag_d, dtag_q, dtag_d;
   logic               push, pop, legal;
`ifdef NTT_SCHED_WDOG_EN
   localparam int WW = $clog2(WDOG_CYCLES) + 1;
   logic [WW-1:0]      wd_q, wd_d;
   logic               trip_q, trip_d;
   assign io.wdog_trip = trip_q;
`endif
   assign head  = mem_q[rd_q];
   assign legal = head[EW-1 -: 8] inside {8'h02, 8'h03, 8'h04, 8'h10, 8'h11, 8'h20, 8'h21, 8'h22};
   // in_ready looks only at the registered count, so a full FIFO refuses a push even during a pop
   assign io.in_ready = ~rst & (cnt_q < (FIFO_AW+1)'(FIFO_DEPTH)) & ~io.flush;
   assign push = io.in_valid & io.in_ready;
   assign pop  = (st_q == S_IDLE) & (cnt_q != '0) & io.eng_ready & ~io.flush;
   assign io.eng_cmd_valid    = vld_q;
   assign io.eng_cmd_opcode   = op_q;
   assign io.eng_cmd_slot     = slot_q;
   assign io.eng_cmd_dma_addr = addr_q;
   assign io.done_valid       = dv_q;
   assign io.done_tag         = dtag_q;
   assign io.done_err         = derr_q;
   assign io.fifo_count       = cnt_q;
   assign io.busy             = (st_q != S_IDLE) | (cnt_q != '0);
   always_ff @(posedge clk)
      if (push) mem_q[wr_q] <= {io.in_opcode, io.in_slot, io.in_dma_addr, io.in_tag};
   always_comb begin
      wr_d   = io.flush ? '0 : wr_q + FIFO_AW'(push);
      rd_d   = io.flush ? '0 : rd_q + FIFO_AW'(pop);
      cnt_d  = io.flush ? '0 : cnt_q + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
      st_d   = st_q;
      vld_d  = 1'b0;
      dv_d   = 1'b0;
      derr_d = 1'b0;
      dtag_d = dtag_q;
      op_d   = op_q;
      slot_d = slot_q;
      addr_d = addr_q;
      tag_d  = tag_q;
`ifdef NTT_SCHED_WDOG_EN
      trip_d = trip_q;
`endif
      case (st_q)
         S_IDLE:
            if (pop && legal) begin
               st_d   = S_ISSUE;
               vld_d  = 1'b1;
               op_d   = head[EW-1 -: 8];
               slot_d = head[EW-9 -: 4];
               addr_d = head[EW-13 -: 48];
               tag_d  = head[TAG_W-1:0];
            end else if (pop) begin
               dv_d   = 1'b1;
               derr_d = 1'b1;
               dtag_d = head[TAG_W-1:0];
            end
         S_ISSUE: st_d = S_WAIT_ACK;
         S_WAIT_ACK:
            if (!io.eng_ready) st_d = S_WAIT_DONE;
`ifdef NTT_SCHED_WDOG_EN
            else if (wd_q == WW'(4)) begin
               st_d   = S_IDLE;
               dv_d   = 1'b1;
               derr_d = 1'b1;
               dtag_d = tag_q;
               trip_d = 1'b1;
            end
`endif
         S_WAIT_DONE:
            if (io.eng_ready) begin
               st_d   = S_IDLE;
               dv_d   = 1'b1;
               dtag_d = tag_q;
            end
`ifdef NTT_SCHED_WDOG_EN
            else if (wd_q == WW'(WDOG_CYCLES - 1)) begin
               st_d   = S_IDLE;
               dv_d   = 1'b1;
               derr_d = 1'b1;
               dtag_d = tag_q;
               trip_d = 1'b1;
            end
`endif
         default: st_d = S_IDLE;
      endcase
`ifdef NTT_SCHED_WDOG_EN
      wd_d = (st_d != st_q) ? '0 : wd_q + WW'(1);
`endif
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_q   <= '0;
         rd_q   <= '0;
         cnt_q  <= '0;
         st_q   <= S_IDLE;
         vld_q  <= 1'b0;
         dv_q   <= 1'b0;
         derr_q <= 1'b0;
         dtag_q <= '0;
         op_q   <= '0;
         slot_q <= '0;
         addr_q <= '0;
         tag_q  <= '0;
`ifdef NTT_SCHED_WDOG_EN
         wd_q   <= '0;
         trip_q <= 1'b0;
`endif
      end else begin
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         cnt_q  <= cnt_d;
         st_q   <= st_d;
         vld_q  <= vld_d;
         dv_q   <= dv_d;
         derr_q <= derr_d;
         dtag_q <= dtag_d;
         op_q   <= op_d;
         slot_q <= slot_d;
         addr_q <= addr_d;
         tag_q  <= tag_d;
`ifdef NTT_SCHED_WDOG_EN
         wd_q   <= wd_d;
         trip_q <= trip_d;
`endif
      end
endmodule

// File: tb/tb_ntt_cmd_sched.sv
// tb_ntt_cmd_sched: directed scoreboard bench for ntt_cmd_sched with a simple engine model.
// Build with NTT_SCHED_WDOG_EN to add the watchdog scenario (WDOG_CYCLES = 16).
module tb_ntt_cmd_sched;
   typedef struct {logic [7:0] op; logic [3:0] slot; logic [47:0] addr;} iss_t;
   typedef struct {logic [7:0] tag; logic err;} dn_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic eng_busy = 1'b0;
   logic hold = 1'b0;
   int   lat = 2;
   int   tests = 0;
   int   fails = 0;
   time  rise_t = 0;
   iss_t exp_iss[$];
   dn_t  exp_dn[$];
   iss_t ei;
   dn_t  ed;
   ntt_cmd_sched_if #(.TAG_W(8), .FIFO_AW(3)) io();
   ntt_cmd_sched #(
      .FIFO_DEPTH(8), .FIFO_AW(3), .TAG_W(8)
`ifdef NTT_SCHED_WDOG_EN
      , .WDOG_CYCLES(16)
`endif
   ) dut (.clk(clk), .rst(rst), .io(io));
   always #5 clk = ~clk;
   assign io.eng_ready = ~(eng_busy | hold);
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   task automatic push(input logic [7:0] op, input logic [3:0] slot, input logic [47:0] addr,
                       input logic [7:0] tag, input bit e_iss, input bit e_dn, input bit err);
      int n = 0;
      io.in_valid    = 1'b1;
      io.in_opcode   = op;
      io.in_slot     = slot;
      io.in_dma_addr = addr;
      io.in_tag      = tag;
      while (!io.in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n == 300) begin
         tests++;
         fails++;
         $display("FAIL push_timeout: tag %0h never accepted", tag);
      end else begin
         if (e_iss) exp_iss.push_back('{op, slot, addr});
         if (e_dn) exp_dn.push_back('{tag, err});
      end
      @(negedge clk);
      io.in_valid = 1'b0;
   endtask
   task automatic wait_idle();
      int n = 0;
      while ((exp_iss.size() != 0 || exp_dn.size() != 0 || io.busy || eng_busy) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n == 2000) begin
         tests++;
         fails++;
         $display("FAIL idle_timeout: iss left %0d done left %0d", exp_iss.size(), exp_dn.size());
      end
      repeat (2) @(negedge clk);
   endtask
   // engine: accepts a strobe by dropping ready for lat cycles
   initial forever begin
      @(negedge clk);
      if (io.eng_cmd_valid) begin
         eng_busy = 1'b1;
         repeat (lat) @(negedge clk);
         eng_busy = 1'b0;
         rise_t = $time;
      end
   end
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         if (io.eng_cmd_valid) begin
            if (exp_iss.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_issue: got opcode %0h expected none", io.eng_cmd_opcode);
            end else begin
               ei = exp_iss.pop_front();
               check("issue_op", 64'(io.eng_cmd_opcode), 64'(ei.op));
               check("issue_slot", 64'(io.eng_cmd_slot), 64'(ei.slot));
               check("issue_addr", 64'(io.eng_cmd_dma_addr), 64'(ei.addr));
            end
         end
         if (io.done_valid) begin
            if (exp_dn.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_done: got tag %0h expected none", io.done_tag);
            end else begin
               ed = exp_dn.pop_front();
               check("done_tag", 64'(io.done_tag), 64'(ed.tag));
               check("done_err", 64'(io.done_err), 64'(ed.err));
               if (!ed.err) check("done_lat", 64'($time - rise_t), 64'd10);
            end
         end
      end
   end
   initial begin
      io.in_valid = 1'b0;
      io.in_opcode = '0;
      io.in_slot = '0;
      io.in_dma_addr = '0;
      io.in_tag = '0;
      io.flush = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_in_ready", 64'(io.in_ready), 64'd0);
      check("rst_busy", 64'(io.busy), 64'd0);
      check("rst_count", 64'(io.fifo_count), 64'd0);
      check("rst_done", 64'(io.done_valid), 64'd0);
      check("rst_strobe", 64'(io.eng_cmd_valid), 64'd0);
      rst = 1'b0;
      #1 check("post_rst_in_ready", 64'(io.in_ready), 64'd1);
      @(negedge clk);
      // single LOAD with 2-cycle engine latency
      push(8'h02, 4'd1, 48'h1000, 8'h05, 1, 1, 0);
      check("lat_pre", 64'(io.eng_cmd_valid), 64'd0);
      @(negedge clk);
      check("lat_issue", 64'(io.eng_cmd_valid), 64'd1);
      check("lat_popped", 64'(io.fifo_count), 64'd0);
      @(negedge clk);
      check("issue_one_cycle", 64'(io.eng_cmd_valid), 64'd0);
      wait_idle();
      check("payload_hold", 64'(io.eng_cmd_dma_addr), 64'h1000);
      // burst of 9 with engine held busy
      hold = 1'b1;
      for (int i = 0; i < 8; i++)
         push((i % 2) ? 8'h21 : 8'h10, 4'(i), 48'(i) * 48'h10, 8'(i), 1, 1, 0);
      check("full_count", 64'(io.fifo_count), 64'd8);
      check("full_in_ready", 64'(io.in_ready), 64'd0);
      check("full_busy", 64'(io.busy), 64'd1);
      hold = 1'b0;
      push(8'h22, 4'd8, 48'h80, 8'h08, 1, 1, 0);
      wait_idle();
      // illegal opcode between two legal ones
      push(8'h10, 4'd2, 48'h2000, 8'h40, 1, 1, 0);
      push(8'h7F, 4'd3, 48'h3000, 8'h33, 0, 1, 1);
      push(8'h20, 4'd4, 48'h4000, 8'h41, 1, 1, 0);
      wait_idle();
      // flush while INTT is in flight
      lat = 10;
      push(8'h11, 4'd5, 48'h5000, 8'h50, 1, 1, 0);
      push(8'h02, 4'd6, 48'h6000, 8'h51, 0, 0, 0);
      push(8'h03, 4'd7, 48'h7000, 8'h52, 0, 0, 0);
      push(8'h04, 4'd8, 48'h8000, 8'h53, 0, 0, 0);
      check("pre_flush_count", 64'(io.fifo_count), 64'd3);
      io.flush = 1'b1;
      #1 check("flush_in_ready", 64'(io.in_ready), 64'd0);
      @(negedge clk);
      io.flush = 1'b0;
      check("flush_count", 64'(io.fifo_count), 64'd0);
      check("flush_busy", 64'(io.busy), 64'd1);
      wait_idle();
`ifdef NTT_SCHED_WDOG_EN
      lat = 100;
      push(8'h10, 4'd9, 48'h9000, 8'h70, 1, 1, 1);
      wait_idle();
      check("wdog_trip", 64'(io.wdog_trip), 64'd1);
`endif
      // reset while waiting for completion
      lat = 10;
      push(8'h02, 4'd1, 48'hA000, 8'h60, 1, 0, 0);
      push(8'h03, 4'd2, 48'hB000, 8'h61, 0, 0, 0);
      repeat (3) @(negedge clk);
      check("pre_rst_busy", 64'(io.busy), 64'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_strobe", 64'(io.eng_cmd_valid), 64'd0);
      check("mid_rst_done", 64'(io.done_valid), 64'd0);
      check("mid_rst_count", 64'(io.fifo_count), 64'd0);
      check("mid_rst_busy", 64'(io.busy), 64'd0);
      check("mid_rst_opcode", 64'(io.eng_cmd_opcode), 64'd0);
      repeat (12) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("post_rst2_in_ready", 64'(io.in_ready), 64'd1);
      check("leftover_expect", 64'(exp_iss.size() + exp_dn.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
